hazard_flush_controller: RTL and testbench

- Pipeline control block that drives stall and flush for the fetch/decode, decode/execute and execute/memory pipeline registers, plus the PC redirect.
- Detects load-use hazards, applies taken-branch/jump redirects from EX, and freezes the pipeline while data memory is busy.
- Holds a redirect that arrives during a memory wait and applies it when the wait ends.
- Keeps saturating performance counters for stall cycles and flush events.

---
 rtl/hazard_flush_controller_pkg.sv | 25 ++
 rtl/hazard_flush_controller_if.sv | 42 ++++
 rtl/sat_counter.sv | 26 ++
 rtl/hazard_flush_controller.sv | 108 ++++++++++
 tb/tb_hazard_flush_controller.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_flush_controller_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, the x0 register
// constant and the stall/flush bundle driven by the hazard controller.
package hazard_flush_controller_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT       = 2'd1,
        WAIT_REDIR = 2'd2
    } hfc_state_e;

    // Per-cycle pipeline control bundle
    typedef struct packed {
        logic pc_stall;
        logic fd_stall;
        logic fd_flush;
        logic de_stall;
        logic de_flush;
        logic em_stall;
        logic pc_redirect;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_flush_controller_if.sv
// Hazard/flush bus between the pipeline and its control block.
//   master: pipeline side, drives ID/EX hazard info and mem_busy, receives controls.
//   slave : controller side.
interface hazard_flush_controller_if #(
    parameter int unsigned XLEN = 32
);
    import hazard_flush_controller_pkg::*;

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_mem_read;
    logic             ex_redirect;
    logic [XLEN-1:0]  ex_target;
    logic             mem_busy;

    logic             pc_stall;
    logic             fd_stall;
    logic             fd_flush;
    logic             de_stall;
    logic             de_flush;
    logic             em_stall;
    logic             pc_redirect;
    logic [XLEN-1:0]  pc_target;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, mem_busy,
        input  pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall,
               pc_redirect, pc_target
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_redirect, ex_target, mem_busy,
        output pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall,
               pc_redirect, pc_target
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear (clear beats increment).
//   clk, reset : clock, async active-high reset
//   inc        : count this cycle
//   clr        : synchronous clear
//   cnt        : current count, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_flush_controller.sv
// Pipeline hazard/flush controller: load-use bubbles, EX redirects, memory-wait
// freeze with deferred redirect, and stall/flush performance counters.
//   clk, reset   : clock, async active-high reset
//   bus          : hazard inputs and combinational stall/flush/redirect outputs
//   stat_clear   : synchronous clear of both counters
//   stall_cycles : cycles with pc_stall=1 (saturating)
//   flush_events : cycles with pc_redirect=1 (saturating)
module hazard_flush_controller
    import hazard_flush_controller_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    hazard_flush_controller_if.slave     bus,
    input  logic                         stat_clear,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic [CNT_W-1:0]             flush_events
);

    hfc_state_e      state_q, state_d;
    logic [XLEN-1:0] pend_q, pend_d;
    pipe_ctrl_t      ctrl_c;
    logic [XLEN-1:0] target_c;
    logic            load_use_c;

    // State and pending-target register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

    // Load-use: EX load writes a non-x0 register the ID instruction reads
    assign load_use_c = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) &&
                        ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                         (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

    // Next state and zero-latency controls
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ctrl_c   = '0;
        target_c = pend_q;

        if (bus.mem_busy) begin
            // Freeze everything; a redirect seen now is deferred (newest wins)
            ctrl_c.pc_stall = 1'b1;
            ctrl_c.fd_stall = 1'b1;
            ctrl_c.de_stall = 1'b1;
            ctrl_c.em_stall = 1'b1;
            if (bus.ex_redirect) begin
                pend_d  = bus.ex_target;
                state_d = WAIT_REDIR;
            end else if (state_q != WAIT_REDIR) begin
                state_d = WAIT;
            end
        end else begin
            state_d = RUN;
            if (bus.ex_redirect) begin
                // Live redirect beats a deferred one; ID is wrong-path so no load-use
                ctrl_c.pc_redirect = 1'b1;
                ctrl_c.fd_flush    = 1'b1;
                ctrl_c.de_flush    = 1'b1;
                target_c           = bus.ex_target;
            end else if (state_q == WAIT_REDIR) begin
                ctrl_c.pc_redirect = 1'b1;
                ctrl_c.fd_flush    = 1'b1;
                ctrl_c.de_flush    = 1'b1;
            end else if (load_use_c) begin
                ctrl_c.pc_stall = 1'b1;
                ctrl_c.fd_stall = 1'b1;
                ctrl_c.de_flush = 1'b1;
            end
        end
    end

    assign bus.pc_stall    = ctrl_c.pc_stall;
    assign bus.fd_stall    = ctrl_c.fd_stall;
    assign bus.fd_flush    = ctrl_c.fd_flush;
    assign bus.de_stall    = ctrl_c.de_stall;
    assign bus.de_flush    = ctrl_c.de_flush;
    assign bus.em_stall    = ctrl_c.em_stall;
    assign bus.pc_redirect = ctrl_c.pc_redirect;
    assign bus.pc_target   = target_c;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl_c.pc_stall),
        .clr   (stat_clear),
        .cnt   (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ctrl_c.pc_redirect),
        .clr   (stat_clear),
        .cnt   (flush_events)
    );

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Self-checking bench for hazard_flush_controller (counters built 4 bits wide).
module tb_hazard_flush_controller;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam int          CMAX  = 15;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             stat_clear = 1'b0;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    hazard_flush_controller_if #(.XLEN(XLEN)) hif();

    hazard_flush_controller #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (hif.slave),
        .stat_clear   (stat_clear),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A redirect is "owed" when one was seen during a memory wait; it is paid
    // on the first non-busy cycle (unless a live redirect pays it instead).
    bit          m_owed;
    logic [31:0] m_tgt;
    int          m_stalls, m_flushes;

    logic        e_hazard, e_redir, e_pc_stall, e_de_flush;
    logic [31:0] e_target;

    always @* begin
        e_hazard   = hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
                     ((hif.id_use_rs1 && hif.id_rs1 == hif.ex_rd) ||
                      (hif.id_use_rs2 && hif.id_rs2 == hif.ex_rd));
        e_redir    = !hif.mem_busy && (hif.ex_redirect || m_owed);
        e_pc_stall = hif.mem_busy || (!e_redir && e_hazard);
        e_de_flush = !hif.mem_busy && (e_redir || e_hazard);
        e_target   = (!hif.mem_busy && hif.ex_redirect) ? hif.ex_target : m_tgt;
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_owed    <= 1'b0;
            m_tgt     <= '0;
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            if (hif.mem_busy && hif.ex_redirect) begin
                m_owed <= 1'b1;
                m_tgt  <= hif.ex_target;
            end else if (!hif.mem_busy) begin
                m_owed <= 1'b0;
            end
            m_stalls  <= stat_clear ? 0 : ((m_stalls + int'(e_pc_stall) > CMAX) ? CMAX : m_stalls + int'(e_pc_stall));
            m_flushes <= stat_clear ? 0 : ((m_flushes + int'(e_redir) > CMAX) ? CMAX : m_flushes + int'(e_redir));
        end
    end

    // Compare every cycle, away from the rising edge
    always @(negedge clk) begin
        #2;
        chk("pc_stall",     64'(hif.pc_stall),    64'(e_pc_stall));
        chk("fd_stall",     64'(hif.fd_stall),    64'(e_pc_stall));
        chk("fd_flush",     64'(hif.fd_flush),    64'(e_redir));
        chk("de_stall",     64'(hif.de_stall),    64'(hif.mem_busy));
        chk("de_flush",     64'(hif.de_flush),    64'(e_de_flush));
        chk("em_stall",     64'(hif.em_stall),    64'(hif.mem_busy));
        chk("pc_redirect",  64'(hif.pc_redirect), 64'(e_redir));
        chk("pc_target",    64'(hif.pc_target),   64'(e_target));
        chk("stall_cycles", 64'(stall_cycles),    64'(m_stalls));
        chk("flush_events", 64'(flush_events),    64'(m_flushes));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit busy, input bit redir, input logic [31:0] tgt,
                         input bit load, input logic [4:0] rd,
                         input logic [4:0] rs1, input bit u1,
                         input logic [4:0] rs2, input bit u2, input bit clr);
        @(negedge clk);
        hif.mem_busy    = busy;
        hif.ex_redirect = redir;
        hif.ex_target   = tgt;
        hif.ex_mem_read = load;
        hif.ex_rd       = rd;
        hif.id_rs1      = rs1;
        hif.id_use_rs1  = u1;
        hif.id_rs2      = rs2;
        hif.id_use_rs2  = u2;
        stat_clear      = clr;
        #3;
    endtask

    task automatic idle();
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
    endtask

    initial begin
        hif.mem_busy = 0; hif.ex_redirect = 0; hif.ex_target = '0;
        hif.ex_mem_read = 0; hif.ex_rd = '0; hif.id_rs1 = '0; hif.id_use_rs1 = 0;
        hif.id_rs2 = '0; hif.id_use_rs2 = 0;

        // Reset state
        idle();
        chk("rst pc_stall", 64'(hif.pc_stall), 64'd0);
        chk("rst pc_target", 64'(hif.pc_target), 64'd0);
        chk("rst stall_cycles", 64'(stall_cycles), 64'd0);
        idle();
        reset = 1'b0;
        idle();

        // Load-use: one bubble
        drive(0, 0, 32'h0, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
        chk("lu pc_stall", 64'(hif.pc_stall), 64'd1);
        chk("lu fd_stall", 64'(hif.fd_stall), 64'd1);
        chk("lu de_flush", 64'(hif.de_flush), 64'd1);
        idle();
        chk("lu stall_cycles", 64'(stall_cycles), 64'd1);

        // Load to x0, and rs2 match with rs2 unused
        drive(0, 0, 32'h0, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0);
        chk("x0 pc_stall", 64'(hif.pc_stall), 64'd0);
        drive(0, 0, 32'h0, 1, 5'd7, 5'd1, 1, 5'd7, 0, 0);
        chk("rs2unused pc_stall", 64'(hif.pc_stall), 64'd0);

        // Branch beats load-use
        drive(0, 1, 32'h0000_0100, 1, 5'd5, 5'd5, 1, 5'd0, 0, 0);
        chk("br pc_redirect", 64'(hif.pc_redirect), 64'd1);
        chk("br pc_target", 64'(hif.pc_target), 64'h100);
        chk("br pc_stall", 64'(hif.pc_stall), 64'd0);
        idle();
        chk("br flush_events", 64'(flush_events), 64'd1);

        // Memory wait with deferred redirect
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1);
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        chk("w1 de_flush", 64'(hif.de_flush), 64'd0);
        drive(1, 1, 32'h0000_0200, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        chk("w2 pc_redirect", 64'(hif.pc_redirect), 64'd0);
        drive(1, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        chk("w3 em_stall", 64'(hif.em_stall), 64'd1);
        drive(0, 0, 32'h0, 1, 5'd3, 5'd3, 1, 5'd0, 0, 0);
        chk("wexit pc_redirect", 64'(hif.pc_redirect), 64'd1);
        chk("wexit pc_target", 64'(hif.pc_target), 64'h200);
        chk("wexit pc_stall", 64'(hif.pc_stall), 64'd0);
        chk("wexit stall_cycles", 64'(stall_cycles), 64'd3);

        // Newest pending target wins
        drive(1, 1, 32'h0000_0300, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        drive(1, 1, 32'h0000_0400, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        drive(0, 0, 32'h0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        chk("newest pc_target", 64'(hif.pc_target), 64'h400);

        // Reset mid-wait drops the pending redirect
        drive(1, 1, 32'h0000_0500, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0);
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        chk("rstwait pc_redirect", 64'(hif.pc_redirect), 64'd0);
        chk("rstwait pc_target", 64'(hif.pc_target), 64'd0);
        chk("rstwait stall_cycles", 64'(stall_cycles), 64'd0);

        // Counter saturation and clear priority
        for (int i = 0; i < 20; i++) drive(0, 0, 32'h0, 1, 5'd9, 5'd0, 0, 5'd9, 1, 0);
        idle();
        chk("sat stall_cycles", 64'(stall_cycles), 64'hF);
        drive(0, 0, 32'h0, 1, 5'd9, 5'd9, 1, 5'd0, 0, 1);
        idle();
        chk("clr stall_cycles", 64'(stall_cycles), 64'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) < 3, $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            else reset = 1'b0;
        end
        reset = 1'b0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
